// File: rtl/fft_pkg.sv
// Shared constants, state type and address helper
// for the RFFT input buffer sequencer.
package fft_pkg;

    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic logic [ADDR_W-1:0] bitrev6(
        input logic [ADDR_W-1:0] a
    );
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_buf_ctrl_if.sv
// Stream and buffer-RAM pins of the RFFT input sequencer.
// master is the sequencer side, slave is its environment.
interface fft_buf_ctrl_if #(
    parameter int WIDTH = 32
);
    import fft_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic              out_last;
    logic              frame_done;
    logic              bram_en;
    logic              bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [WIDTH-1:0]  bram_di;
    logic [WIDTH-1:0]  bram_do;

    modport master (
        input  in_valid, in_data, out_ready, bram_do,
        output in_ready, out_valid, out_data, out_last,
        output frame_done, bram_en, bram_we, bram_addr, bram_di
    );

    modport slave (
        output in_valid, in_data, out_ready, bram_do,
        input  in_ready, out_valid, out_data, out_last,
        input  frame_done, bram_en, bram_we, bram_addr, bram_di
    );

endinterface

// File: rtl/fft_buf_ctrl_fifo.sv
// Two-entry output FIFO holding {last, data} words
// returned from the buffer RAM.
module skid_fifo2 #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last
);

    logic [WIDTH:0] mem [2];
    logic           wp;
    logic           rp;
    logic [1:0]     cnt;

    // Pointer and occupancy bookkeeping; payload slots need no reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wp  <= 1'b0;
            rp  <= 1'b0;
            cnt <= 2'd0;
        end else begin
            if (push) begin
                mem[wp] <= {push_last, push_data};
                wp      <= ~wp;
            end
            if (pop) begin
                rp <= ~rp;
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign occ       = cnt;
    assign head_data = mem[rp][WIDTH-1:0];
    assign head_last = mem[rp][WIDTH];

endmodule

// File: rtl/fft_buf_ctrl.sv
// Fills a 64-word buffer RAM in natural order, then drains it
// (optionally bit-reversed) through a 2-deep output FIFO.
module fft_buf_ctrl
    import fft_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int BITREV = 1
) (
    input logic Clk,
    input logic Rst,
    fft_buf_ctrl_if.master bus
);

    localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);

    state_t            state;
    logic [6:0]        wcnt;
    logic [6:0]        rcnt;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        occ;
    logic [1:0]        pend;
    logic [WIDTH-1:0]  head_data;
    logic              head_last;
    logic              wr;
    logic              pop;
    logic              issue;
    logic              last_pop;
    logic [ADDR_W-1:0] rd_addr;

    assign bus.in_ready   = (state == FILL);
    assign bus.out_valid  = (occ != 2'd0);
    assign bus.out_data   = head_data;
    assign bus.out_last   = bus.out_valid && head_last;
    assign bus.frame_done = last_pop;

    // Handshakes and the read-issue decision; a read may only be
    // launched when the FIFO is sure to have room on its return.
    always_comb begin
        wr       = (state == FILL) && bus.in_valid;
        pop      = bus.out_valid && bus.out_ready;
        last_pop = pop && head_last;
        pend     = occ + {1'b0, inflight};
        issue    = (state == DRAIN) && !rcnt[6] &&
                   ((pend < 2'd2) || ((pend == 2'd2) && pop));
        rd_addr  = (BITREV != 0) ? bitrev6(rcnt[ADDR_W-1:0])
                                 : rcnt[ADDR_W-1:0];
    end

    // RAM pins: write in FILL, read in DRAIN, idle pins held at zero.
    always_comb begin
        bus.bram_en   = 1'b0;
        bus.bram_we   = 1'b0;
        bus.bram_addr = '0;
        bus.bram_di   = '0;
        unique case (1'b1)
            wr: begin
                bus.bram_en   = 1'b1;
                bus.bram_we   = 1'b1;
                bus.bram_addr = wcnt[ADDR_W-1:0];
                bus.bram_di   = bus.in_data;
            end
            issue: begin
                bus.bram_en   = 1'b1;
                bus.bram_addr = rd_addr;
            end
            default: ;
        endcase
    end

    // Fill/drain sequencing and the one-cycle read-return tracker.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state         <= FILL;
            wcnt          <= '0;
            rcnt          <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= issue;
            inflight_last <= issue && (rcnt == LAST_IDX);
            unique case (state)
                FILL: begin
                    if (wr) begin
                        if (wcnt == LAST_IDX) begin
                            state <= DRAIN;
                            wcnt  <= '0;
                        end else begin
                            wcnt <= wcnt + 7'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        rcnt <= rcnt + 7'd1;
                    end
                    if (last_pop) begin
                        state <= FILL;
                        rcnt  <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    skid_fifo2 #(
        .WIDTH(WIDTH)
    ) u_obuf (
        .Clk       (Clk),
        .Rst       (Rst),
        .push      (inflight),
        .push_data (bus.bram_do),
        .push_last (inflight_last),
        .pop       (pop),
        .occ       (occ),
        .head_data (head_data),
        .head_last (head_last)
    );

endmodule
